// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   Architectural register file for the MIPS datapath. It has NREGS registers
//   of WIDTH bits, one write port and two combinational read ports. Register 0
//   is hard-wired to zero and has no storage. Registers 1..NREGS-1 are
//   enable-gated flops with an asynchronous clear.
//
//   Write-back commits rd in the same cycle that decode reads rs/rt. A read
//   port therefore returns the incoming write data when it addresses the
//   register being written (write-through bypass).
//
// Ports
//   clk          in   1      rising-edge clock
//   clr          in   1      asynchronous active-high clear of all registers
//   ctrl_we      in   1      write enable
//   ctrl_wreg    in   AW     write address
//   data_wr      in   WIDTH  write data
//   ctrl_rreg_a  in   AW     read address, port A
//   ctrl_rreg_b  in   AW     read address, port B
//   data_ra      out  WIDTH  read data, port A (combinational)
//   data_rb      out  WIDTH  read data, port B (combinational)
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_we,
    input  logic [AW-1:0]    ctrl_wreg,
    input  logic [WIDTH-1:0] data_wr,
    input  logic [AW-1:0]    ctrl_rreg_a,
    input  logic [AW-1:0]    ctrl_rreg_b,
    output logic [WIDTH-1:0] data_ra,
    output logic [WIDTH-1:0] data_rb
);

    // Storage for registers 1..NREGS-1 only; register 0 does not exist.
    logic [WIDTH-1:0] regs [1:NREGS-1];

    // A write to address 0 never qualifies, so it is dropped with no effect.
    logic wr_valid;
    assign wr_valid = ctrl_we && (ctrl_wreg != '0);

    // Each register loads only when it is the write target. With ctrl_we low
    // no register is enabled, so an unknown write address cannot disturb
    // the stored state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int r = 1; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_valid && (ctrl_wreg == AW'(r))) begin
                    regs[r] <= data_wr;
                end
            end
        end
    end

    // Read mux. Address 0 matches no register and yields zero. The mux is
    // a compare-and-select loop, so no index can fall outside the array.
    function automatic logic [WIDTH-1:0] read_mux(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (addr == AW'(r)) begin
                val = regs[r];
            end
        end
        return val;
    endfunction

    // Read port: clear has priority. The write-through bypass comes next,
    // then the stored value.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        if (clr) begin
            val = '0;
        end else if (wr_valid && (ctrl_wreg == addr)) begin
            val = data_wr;
        end else begin
            val = read_mux(addr);
        end
        return val;
    endfunction

    always_comb begin
        data_ra = read_port(ctrl_rreg_a);
        data_rb = read_port(ctrl_rreg_b);
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//   Directed table of write/read vectors with hand-computed expectations, plus
//   hand-written sequences for clear, X-address and random operation against a
//   behavioural array model. Inputs change on the falling edge. Outputs are
//   sampled 1 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             clr;
    logic             ctrl_we;
    logic [AW-1:0]    ctrl_wreg;
    logic [WIDTH-1:0] data_wr;
    logic [AW-1:0]    ctrl_rreg_a;
    logic [AW-1:0]    ctrl_rreg_b;
    logic [WIDTH-1:0] data_ra;
    logic [WIDTH-1:0] data_rb;

    int checks;
    int errors;

    regfile_2r1w #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk         (clk),
        .clr         (clr),
        .ctrl_we     (ctrl_we),
        .ctrl_wreg   (ctrl_wreg),
        .data_wr     (data_wr),
        .ctrl_rreg_a (ctrl_rreg_a),
        .ctrl_rreg_b (ctrl_rreg_b),
        .data_ra     (data_ra),
        .data_rb     (data_rb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             we;
        logic [AW-1:0]    wreg;
        logic [WIDTH-1:0] wd;
        logic [AW-1:0]    ra;
        logic [AW-1:0]    rb;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
    } vec_t;

    vec_t vecs [12];

    logic [WIDTH-1:0] mdl [NREGS];

    task automatic check(input string nm, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one set of inputs on the falling edge and let them settle.
    task automatic drive(input logic we, input logic [AW-1:0] wreg,
                         input logic [WIDTH-1:0] wd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb);
        @(negedge clk);
        ctrl_we     = we;
        ctrl_wreg   = wreg;
        data_wr     = wd;
        ctrl_rreg_a = ra;
        ctrl_rreg_b = rb;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Expected values are what the ports show before the rising edge.
        // Where a write targets the read address, that is the bypassed data.
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd7,  32'h00000000, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vecs[5]  = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd7,  32'h00000000, 32'h12345678};
        vecs[6]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h00000000};
        vecs[7]  = '{1'b1, 5'd1,  32'h5A5A5A5A, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[8]  = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd7,  32'h11111111, 32'h11111111};
        vecs[9]  = '{1'b1, 5'd7,  32'h22222222, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'd7,  32'h00000000, 5'd7,  5'd31, 32'h22222222, 32'hA5A5A5A5};
        vecs[11] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd30, 32'h5A5A5A5A, 32'h00000000};

        // Reset state: outputs are zero while clr is high, even with a bypass request.
        clr         = 1'b1;
        ctrl_we     = 1'b1;
        ctrl_wreg   = 5'd3;
        data_wr     = 32'hCAFEF00D;
        ctrl_rreg_a = 5'd3;
        ctrl_rreg_b = 5'd3;
        #1;
        check("reset_ra", data_ra, 32'h0);
        check("reset_rb", data_rb, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_ra", data_ra, 32'h0);
        @(negedge clk);
        clr     = 1'b0;
        ctrl_we = 1'b0;

        // Every address reads zero after clear.
        for (int i = 0; i < NREGS; i++) begin
            drive(1'b0, 5'd0, 32'h0, AW'(i), AW'(NREGS - 1 - i));
            check("clr_all_a", data_ra, 32'h0);
            check("clr_all_b", data_rb, 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].wreg, vecs[i].wd, vecs[i].ra, vecs[i].rb);
            check($sformatf("vec%0d_a", i), data_ra, vecs[i].ea);
            check($sformatf("vec%0d_b", i), data_rb, vecs[i].eb);
        end

        // Unknown write address with the write enable low must leave state intact.
        @(negedge clk);
        ctrl_we   = 1'b0;
        ctrl_wreg = 'x;
        data_wr   = 32'hBADBAD00;
        @(posedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
        check("xaddr_r7", data_ra, 32'h22222222);
        check("xaddr_r31", data_rb, 32'hA5A5A5A5);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
        check("xaddr_r5", data_ra, 32'hDEADBEEF);
        check("xaddr_r1", data_rb, 32'h5A5A5A5A);

        // Asynchronous clear between edges, with a write pending.
        drive(1'b1, 5'd5, 32'h77777777, 5'd31, 5'd1);
        #2;
        clr = 1'b1;
        #1;
        check("aclr_r31", data_ra, 32'h0);
        check("aclr_r1", data_rb, 32'h0);
        @(posedge clk);
        #1;
        ctrl_rreg_a = 5'd5;
        #1;
        check("aclr_lost_write", data_ra, 32'h0);
        @(negedge clk);
        clr     = 1'b0;
        ctrl_we = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
        check("post_clr_r31", data_ra, 32'h0);
        check("post_clr_r1", data_rb, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        check("post_clr_r5", data_ra, 32'h0);
        check("post_clr_r7", data_rb, 32'h0);

        // First edge after release accepts a write.
        drive(1'b1, 5'd3, 32'h0BADF00D, 5'd2, 5'd2);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
        check("wr_after_clr_r3", data_ra, 32'h0BADF00D);
        check("wr_after_clr_r31", data_rb, 32'h0);

        // Random operation against an array model, with occasional clear pulses.
        for (int r = 0; r < NREGS; r++) mdl[r] = '0;
        mdl[3] = 32'h0BADF00D;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [WIDTH-1:0] ea;
            logic [WIDTH-1:0] eb;
            @(negedge clk);
            clr         = ($urandom_range(0, 49) == 0);
            ctrl_we     = $urandom_range(0, 1) == 1;
            ctrl_wreg   = AW'($urandom_range(0, NREGS - 1));
            data_wr     = $urandom;
            ctrl_rreg_a = AW'($urandom_range(0, NREGS - 1));
            ctrl_rreg_b = AW'($urandom_range(0, NREGS - 1));
            if (clr) begin
                for (int r = 0; r < NREGS; r++) mdl[r] = '0;
            end
            if (clr) begin
                ea = '0;
                eb = '0;
            end else begin
                ea = mdl[ctrl_rreg_a];
                eb = mdl[ctrl_rreg_b];
                if (ctrl_we && ctrl_wreg != 0 && ctrl_wreg == ctrl_rreg_a) ea = data_wr;
                if (ctrl_we && ctrl_wreg != 0 && ctrl_wreg == ctrl_rreg_b) eb = data_wr;
            end
            #1;
            check("rand_a", data_ra, ea);
            check("rand_b", data_rb, eb);
            if (!clr && ctrl_we && ctrl_wreg != 0) mdl[ctrl_wreg] = data_wr;
        end
        @(negedge clk);
        clr     = 1'b0;
        ctrl_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
